// File: rtl/sdpram_be_ctrl.sv
// Single-clock simple-dual-port RAM with byte-enable writes, 1- or 2-cycle read latency,
// same-cycle write-to-read forwarding and a sequential zero-fill engine.
module sdpram_be_ctrl #(
   parameter int ADDR_WIDTH     = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_SIZE      = 8,
   parameter int OUTPUT_REG     = 0,
   parameter int BYPASS_EN      = 1,
   parameter int CLEAR_ON_RESET = 1,
   localparam int BE_WIDTH      = DATA_WIDTH / BYTE_SIZE
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [BE_WIDTH-1:0]   wr_byte_en,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  clear_req,
   output logic                  init_busy
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

   typedef enum logic {S_RUN = 1'b0, S_CLEAR = 1'b1} state_t;

   state_t                state;
   logic [ADDR_WIDTH:0]   cnt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  wr_acc;
   logic                  rd_acc;
   logic                  collide;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] data_p0;
   logic                  vld_p0;

   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0] old_w,
      input logic [DATA_WIDTH-1:0] new_w,
      input logic [BE_WIDTH-1:0]   be
   );
      logic [DATA_WIDTH-1:0] res;
      res = old_w;
      for (int i = 0; i < BE_WIDTH; i++) begin
         if (be[i]) res[i*BYTE_SIZE +: BYTE_SIZE] = new_w[i*BYTE_SIZE +: BYTE_SIZE];
      end
      return res;
   endfunction

   assign wr_acc  = wr_en & ~init_busy;
   assign rd_acc  = rd_en & ~init_busy;
   assign collide = wr_acc & rd_acc & (wr_addr == rd_addr);

   // Clear engine: the counter carries one extra bit so it can step past the last address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
         init_busy <= (CLEAR_ON_RESET != 0);
         cnt       <= '0;
      end else begin
         case (state)
            S_CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state     <= S_RUN;
                  init_busy <= 1'b0;
               end
            end
            default: begin
               if (clear_req) begin
                  state     <= S_CLEAR;
                  init_busy <= 1'b1;
                  cnt       <= '0;
               end
            end
         endcase
      end
   end

   // Array is only touched by the clear engine or an accepted write
   always_ff @(posedge clk) begin
      if (state == S_CLEAR) begin
         mem[cnt[ADDR_WIDTH-1:0]] <= '0;
      end else if (wr_acc) begin
         mem[wr_addr] <= merge_lanes(mem[wr_addr], wr_data, wr_byte_en);
      end
   end

   always_comb begin
      rd_word = mem[rd_addr];
      if ((BYPASS_EN != 0) && collide) rd_word = merge_lanes(rd_word, wr_data, wr_byte_en);
   end

   // Stage p0: array read capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0  <= 1'b0;
         data_p0 <= '0;
      end else begin
         vld_p0 <= rd_acc;
         if (rd_acc) data_p0 <= rd_word;
      end
   end

   generate
      if (OUTPUT_REG != 0) begin : g_oreg
         logic [DATA_WIDTH-1:0] data_p1;
         logic                  vld_p1;

         // Stage p1: optional output register
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               vld_p1  <= 1'b0;
               data_p1 <= '0;
            end else begin
               vld_p1 <= vld_p0;
               if (vld_p0) data_p1 <= data_p0;
            end
         end

         assign rd_data  = data_p1;
         assign rd_valid = vld_p1;
      end else begin : g_noreg
         assign rd_data  = data_p0;
         assign rd_valid = vld_p0;
      end
   endgenerate

endmodule

// File: tb/tb_sdpram_be_ctrl.sv
// Bench for sdpram_be_ctrl: two instances (latency 1 with forwarding, latency 2 without) share
// one stimulus stream and are compared every cycle against a behavioural memory/queue model.
module tb_sdpram_be_ctrl;

   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int BEW   = 4;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [BEW-1:0] wr_byte_en = '0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          clear_req = 1'b0;

   logic [DW-1:0] rd_data0, rd_data1;
   logic          rd_valid0, rd_valid1;
   logic          busy0, busy1;

   sdpram_be_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SIZE(8), .OUTPUT_REG(0),
                    .BYPASS_EN(1), .CLEAR_ON_RESET(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
      .rd_valid(rd_valid0), .clear_req(clear_req), .init_busy(busy0));

   sdpram_be_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SIZE(8), .OUTPUT_REG(1),
                    .BYPASS_EN(0), .CLEAR_ON_RESET(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
      .rd_valid(rd_valid1), .clear_req(clear_req), .init_busy(busy1));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int            due;
      logic [DW-1:0] d;
   } rd_t;

   logic [DW-1:0] mem_m [DEPTH];
   rd_t           q0[$];
   rd_t           q1[$];
   int            cyc_n = 0;
   int            busy_left = DEPTH;
   logic          exp_vld0 = 1'b0, exp_vld1 = 1'b0;
   logic [DW-1:0] exp_dat0 = '0, exp_dat1 = '0;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                           input logic [BEW-1:0] be);
      logic [DW-1:0] r;
      r = o;
      for (int i = 0; i < BEW; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
      return r;
   endfunction

   task automatic model_reset();
      q0.delete();
      q1.delete();
      exp_vld0 = 1'b0; exp_vld1 = 1'b0;
      exp_dat0 = '0;   exp_dat1 = '0;
      busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
   endtask

   task automatic model_edge();
      logic [DW-1:0] old_w;
      logic          coll;
      if (!rst_n) return;
      cyc_n++;
      if (busy_left > 0) begin
         busy_left--;
      end else begin
         old_w = mem_m[rd_addr];
         coll  = wr_en && (wr_addr == rd_addr);
         if (rd_en) begin
            q0.push_back('{cyc_n, coll ? merge(old_w, wr_data, wr_byte_en) : old_w});
            q1.push_back('{cyc_n + 1, old_w});
         end
         if (wr_en) mem_m[wr_addr] = merge(mem_m[wr_addr], wr_data, wr_byte_en);
         if (clear_req) begin
            busy_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
         end
      end
      exp_vld0 = 1'b0;
      if (q0.size() > 0 && q0[0].due == cyc_n) begin
         exp_vld0 = 1'b1;
         exp_dat0 = q0.pop_front().d;
      end
      exp_vld1 = 1'b0;
      if (q1.size() > 0 && q1[0].due == cyc_n) begin
         exp_vld1 = 1'b1;
         exp_dat1 = q1.pop_front().d;
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("vld0",  {31'd0, rd_valid0}, {31'd0, exp_vld0});
         chk("dat0",  rd_data0, exp_dat0);
         chk("busy0", {31'd0, busy0}, {31'd0, busy_left > 0});
         chk("vld1",  {31'd0, rd_valid1}, {31'd0, exp_vld1});
         chk("dat1",  rd_data1, exp_dat1);
         chk("busy1", {31'd0, busy1}, {31'd0, busy_left > 0});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0; wr_byte_en = '0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_byte_en = be;
      cyc();
      idle();
   endtask

   task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] r0, output logic [DW-1:0] r1);
      rd_en = 1'b1; rd_addr = a;
      cyc();
      idle();
      r0 = rd_data0;
      cyc();
      r1 = rd_data1;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy0 && n < 1100) begin
         cyc();
         n++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] r0, r1;
      int            n, first, cnt_v;
      logic          v1 [12];
      logic [DW-1:0] d1 [12];

      model_reset();
      idle();
      repeat (3) cyc();
      chk_on = 1'b1;
      chk("t1_rst_data0", rd_data0, 32'h0);
      chk("t1_rst_vld1", {31'd0, rd_valid1}, 32'h0);

      // T1: clear after reset release, reads during busy are dropped
      rst_n = 1'b1;
      rd_en = 1'b1; rd_addr = 10'h005;
      count_busy(n);
      rd_en = 1'b0;
      chk("t1_busy_len", n, 1024);
      rd(10'h005, r0, r1);
      chk("t1_rd005_0", r0, 32'h0);
      chk("t1_rd005_1", r1, 32'h0);
      rd(10'h3FF, r0, r1);
      chk("t1_rd3ff_0", r0, 32'h0);

      // T2: byte enables
      wr(10'h010, 32'hAABBCCDD, 4'hF);
      wr(10'h010, 32'h11223344, 4'b0101);
      wr(10'h011, 32'hFFFFFFFF, 4'h0);
      rd(10'h010, r0, r1);
      chk("t2_be_0", r0, 32'hAA22CC44);
      chk("t2_be_1", r1, 32'hAA22CC44);
      rd(10'h011, r0, r1);
      chk("t2_be0_noop", r0, 32'h0);

      // T3: same-cycle collision
      wr(10'h020, 32'hAABBCCDD, 4'hF);
      wr_en = 1'b1; wr_addr = 10'h020; wr_data = 32'h11223344; wr_byte_en = 4'b1100;
      rd_en = 1'b1; rd_addr = 10'h020;
      cyc();
      idle();
      chk("t3_coll_bypass", rd_data0, 32'h1122CCDD);
      cyc();
      chk("t3_coll_nobypass", rd_data1, 32'hAABBCCDD);
      rd(10'h020, r0, r1);
      chk("t3_after_0", r0, 32'h1122CCDD);
      chk("t3_after_1", r1, 32'h1122CCDD);
      // a write right behind a read must not disturb the read in the output stage
      rd_en = 1'b1; rd_addr = 10'h020;
      cyc();
      rd_en = 1'b0;
      wr_en = 1'b1; wr_addr = 10'h020; wr_data = 32'h55555555; wr_byte_en = 4'hF;
      cyc();
      idle();
      chk("t3_inflight_1", rd_data1, 32'h1122CCDD);
      rd(10'h020, r0, r1);
      chk("t3_late_0", r0, 32'h55555555);

      // T4: back-to-back reads, latency 2 instance
      for (int i = 0; i < 8; i++) wr(AW'(i), 32'hC0DE0000 + i, 4'hF);
      for (int k = 0; k < 12; k++) begin
         rd_en = (k < 8); rd_addr = AW'(k);
         cyc();
         v1[k] = rd_valid1;
         d1[k] = rd_data1;
      end
      idle();
      first = -1; cnt_v = 0;
      for (int k = 0; k < 12; k++) begin
         if (v1[k]) begin
            if (first < 0) first = k;
            cnt_v++;
         end
      end
      chk("t4_first_valid", first, 1);
      chk("t4_valid_len", cnt_v, 8);
      chk("t4_data0", d1[1], 32'hC0DE0000);
      chk("t4_data7", d1[8], 32'hC0DE0007);

      // T5: clear_req with a read in the same cycle; write and clear_req during busy ignored
      rd_en = 1'b1; rd_addr = 10'h001; clear_req = 1'b1;
      cyc();
      idle();
      chk("t5_rd_with_clear", rd_data0, 32'hC0DE0001);
      chk("t5_busy_start", {31'd0, busy0}, 32'h1);
      n = 0;
      while (busy0 && n < 1100) begin
         wr_en = (n == 10); wr_addr = 10'h002; wr_data = 32'hDEADBEEF; wr_byte_en = 4'hF;
         clear_req = (n == 20);
         cyc();
         n++;
      end
      idle();
      chk("t5_busy_len", n, 1024);
      for (int a = 0; a < 4; a++) begin
         rd(AW'(a), r0, r1);
         chk("t5_zero_0", r0, 32'h0);
         chk("t5_zero_1", r1, 32'h0);
      end

      // T6: reset in the middle of a clear
      wr(10'h040, 32'h12345678, 4'hF);
      rd(10'h040, r0, r1);
      chk("t6_pre_1", r1, 32'h12345678);
      clear_req = 1'b1;
      cyc();
      idle();
      repeat (500) cyc();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t6_rst_data0", rd_data0, 32'h0);
      chk("t6_rst_data1", rd_data1, 32'h0);
      chk("t6_rst_vld1", {31'd0, rd_valid1}, 32'h0);
      chk("t6_rst_busy", {31'd0, busy0}, 32'h1);
      repeat (3) cyc();
      rst_n = 1'b1;
      count_busy(n);
      chk("t6_busy_len", n, 1024);
      rd(10'h040, r0, r1);
      chk("t6_cleared", r1, 32'h0);

      cyc();
      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
